clock_reset_sequencer: RTL and testbench
========================================

# clock_reset_sequencer

Parametrised clock/reset distribution block that fans one clock to `N_CHANNELS` downstream domains and drives each domain's reset from registered logic. After global reset, it holds every channel's reset and then releases the channels one at a time in staggered order. Once all channels are released, any single channel can be re-reset on request through a req/ack handshake without disturbing the others. It sits between the top-level clock/reset source and the subsystem clock groups.

## Interface
Parameters:
- `N_CHANNELS`, default 5: number of output clock/reset channels; must be ≥1.
- `HOLD_CYCLES`, default 8: minimum reset assertion length, in cycles, for both the global hold and per-channel resets; must be ≥1.
- `STAGGER_CYCLES`, default 4: cycles between consecutive channel releases; must be ≥1.

Ports:
- `clock` in 1: the single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `chan_reset_req` in N_CHANNELS: per-channel re-reset request. Level signal held by the requester until its ack.
- `auto_out_clock` out N_CHANNELS: every bit is `clock`, combinational pass-through with no gating.
- `auto_out_reset` out N_CHANNELS: registered, active-high reset per channel.
- `chan_reset_ack` out N_CHANNELS: one-cycle pulse when a requested channel reset completes.
- `all_released` out 1: registered; high once every channel has completed its initial release.

## Operation
FSM states are HOLD, RELEASE and RUN.

Values while `reset`=1:
- state=HOLD, global counter=0, channel index=0.
- `auto_out_reset`=all ones, `chan_reset_ack`=0, `all_released`=0.
- All per-channel counters=0; all arm bits=1.

HOLD:
- The global counter increments each cycle.
- After `HOLD_CYCLES` cycles, deassert `auto_out_reset[0]` and go to RELEASE with index=1 and counter=0.
- If `N_CHANNELS`=1, go directly to RUN and set `all_released`.

RELEASE:
- The counter counts `STAGGER_CYCLES`.
- Each time it expires, deassert `auto_out_reset[index]`, increment index and clear the counter.
- When channel N-1 is released, set `all_released`=1 on the same edge and go to RUN.

RUN:
- Channels are handled independently, each with its own down-counter sized for `HOLD_CYCLES` and one arm bit.
- A channel is idle when its counter is 0.
- If a channel is idle, armed, and its `chan_reset_req`=1:
  - set `auto_out_reset[i]`=1, load the counter with `HOLD_CYCLES`, clear arm;
  - the counter decrements each cycle;
  - on the edge where it reaches 0, drop `auto_out_reset[i]` and assert `chan_reset_ack[i]` for exactly one cycle.
- Arm is set again only after `chan_reset_req[i]` has been sampled low. A request held high after its ack does not re-trigger.
- Several channels may be in re-reset at once; they do not interact.
- `all_released` stays 1 throughout RUN.

Boundary conditions:
- Requests seen in HOLD or RELEASE are ignored, with no ack. A request still high on entry to RUN is serviced from the first RUN cycle.
- A request on a channel that is already in re-reset is ignored until that channel is idle and re-armed.
- `reset`=1 mid-sequence or mid-re-reset returns everything to reset values at that edge. A pending ack is dropped.
- The state is 2-bit. An illegal state is treated as HOLD.

## Timing
Let E0 be the first rising edge at which `reset` is sampled low. Edges are numbered from E0.
- `auto_out_reset[i]` falls after edge E(HOLD_CYCLES + i·STAGGER_CYCLES).
- `all_released` rises with channel N-1.
- With defaults: ch0 falls at E8, ch1 at E12, …, ch4 at E24; `all_released` rises at E24.

Per-channel re-reset in RUN:
- Request sampled at edge Ek.
- `auto_out_reset[i]` is high from Ek to E(k+HOLD_CYCLES), i.e. exactly `HOLD_CYCLES` cycles.
- `chan_reset_ack[i]` is high for the single cycle after E(k+HOLD_CYCLES).

`auto_out_clock` has zero latency because it is a wire.

## Test plan
- Defaults, release reset at E0 → `auto_out_reset` steps 11111→11110 at E8, then one bit clears every 4 edges; reaches 00000 with `all_released`=1 at E24.
- RUN, `chan_reset_req[2]` pulsed high at E30 and held until ack → `auto_out_reset[2]` high for 8 cycles, falls at E38; ack pulses once at E38; no other bits change.
- RUN, requests on ch0 and ch3 at the same edge → both resets are high for 8 cycles and both acks pulse on the same cycle. Req held high for 3 more cycles → no second reset; drop req then raise it again → a new 8-cycle reset.
- `chan_reset_req[1]`=1 from E2 during HOLD/RELEASE → no ack before E24; re-reset of ch1 starts at E25 (first RUN cycle) and ack arrives 8 cycles later.
- `reset` asserted at E15 (mid-RELEASE) and again during a ch4 re-reset → outputs immediately return to all-ones reset with ack=0 and `all_released`=0; the sequence restarts cleanly.
- Parameter sweep: `N_CHANNELS`=1, `HOLD_CYCLES`=1, `STAGGER_CYCLES`=1 → ch0 falls at E1 with `all_released`; a re-reset lasts 1 cycle with ack on the next edge.

Source files
------------

// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer: fans one clock out to N_CHANNELS domains and drives
// each domain's reset from registered logic. After global reset every channel
// is held, then channels are released one at a time in staggered order. Once
// all are released, any channel can be re-reset through a req/ack handshake.
module clock_reset_sequencer #(
  parameter int N_CHANNELS     = 5,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] chan_reset_req,
  output logic [N_CHANNELS-1:0] auto_out_clock,
  output logic [N_CHANNELS-1:0] auto_out_reset,
  output logic [N_CHANNELS-1:0] chan_reset_ack,
  output logic                  all_released
);

  // Global counter serves both the hold phase and the stagger phase.
  localparam int GCNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int GCNT_W   = $clog2(GCNT_MAX + 1);
  localparam int CCNT_W   = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  // Hold counts from the first unreset edge, so it ends on value HOLD_CYCLES.
  // Stagger counts from the edge that cleared it, so it ends one value earlier.
  localparam logic [GCNT_W-1:0] HOLD_END    = GCNT_W'(HOLD_CYCLES);
  localparam logic [GCNT_W-1:0] STAGGER_END = GCNT_W'(STAGGER_CYCLES - 1);
  localparam logic [GCNT_W-1:0] GCNT_ONE    = GCNT_W'(1);
  localparam logic [CCNT_W-1:0] CH_LOAD     = CCNT_W'(HOLD_CYCLES);
  localparam logic [CCNT_W-1:0] CCNT_ONE    = CCNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_CHANNELS - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [GCNT_W-1:0]                   gcnt_q, gcnt_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [N_CHANNELS-1:0]               rst_q, rst_d;
  logic [N_CHANNELS-1:0]               ack_q, ack_d;
  logic                                all_q, all_d;
  logic [N_CHANNELS-1:0][CCNT_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [N_CHANNELS-1:0]               arm_q, arm_d;

  // Clock fan-out is a plain wire per channel: no gating, no latency.
  assign auto_out_clock = {N_CHANNELS{clock}};

  assign auto_out_reset = rst_q;
  assign chan_reset_ack = ack_q;
  assign all_released   = all_q;

  // Next-state logic for the sequencer FSM and the per-channel re-reset engines.
  always_comb begin
    // NOTE: every target gets a default up front so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    idx_d    = idx_q;
    rst_d    = rst_q;
    ack_d    = '0;
    all_d    = all_q;
    ch_cnt_d = ch_cnt_q;
    arm_d    = arm_q;

    case (state_q)
      S_RELEASE: begin
        if (gcnt_q == STAGGER_END) begin
          for (int i = 0; i < N_CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) rst_d[i] = 1'b0;
          end
          gcnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_RUN;
            all_d   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          gcnt_d = gcnt_q + GCNT_ONE;
        end
      end

      S_RUN: begin
        for (int i = 0; i < N_CHANNELS; i++) begin
          // Re-arm only once the requester has been seen to drop its level.
          if (!chan_reset_req[i]) arm_d[i] = 1'b1;
          if (ch_cnt_q[i] != '0) begin
            ch_cnt_d[i] = ch_cnt_q[i] - CCNT_ONE;
            if (ch_cnt_q[i] == CCNT_ONE) begin
              rst_d[i] = 1'b0;
              ack_d[i] = 1'b1;
            end
          end else if (arm_q[i] && chan_reset_req[i]) begin
            rst_d[i]    = 1'b1;
            ch_cnt_d[i] = CH_LOAD;
            arm_d[i]    = 1'b0;
          end
        end
      end

      // HOLD, and any illegal encoding, behave as the global hold phase.
      default: begin
        state_d = S_HOLD;
        if (gcnt_q >= HOLD_END) begin
          rst_d[0] = 1'b0;
          gcnt_d   = '0;
          idx_d    = IDX_ONE;
          if (N_CHANNELS == 1) begin
            state_d = S_RUN;
            all_d   = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          gcnt_d = gcnt_q + GCNT_ONE;
        end
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_HOLD;
      gcnt_q   <= '0;
      idx_q    <= '0;
      rst_q    <= '1;
      ack_q    <= '0;
      all_q    <= 1'b0;
      // NOTE: the per-channel counters are reset even though they form an
      // array, because a zero count is what marks a channel as idle.
      ch_cnt_q <= '0;
      arm_q    <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      idx_q    <= idx_d;
      rst_q    <= rst_d;
      ack_q    <= ack_d;
      all_q    <= all_d;
      ch_cnt_q <= ch_cnt_d;
      arm_q    <= arm_d;
    end
  end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer: default instance (5/8/4) plus a
// minimal instance (1/1/1). Outputs are sampled 1 time unit after each edge.
module tb_clock_reset_sequencer;

  localparam int N = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default-parameter instance.
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] aoc;
  logic [N-1:0] rst;
  logic [N-1:0] ack;
  logic         all_rel;

  // Minimal-parameter instance.
  logic         reset_b;
  logic [0:0]   req_b;
  logic [0:0]   aoc_b;
  logic [0:0]   rst_b;
  logic [0:0]   ack_b;
  logic         all_rel_b;

  clock_reset_sequencer #(
    .N_CHANNELS    (5),
    .HOLD_CYCLES   (8),
    .STAGGER_CYCLES(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .chan_reset_req(req),
    .auto_out_clock(aoc),
    .auto_out_reset(rst),
    .chan_reset_ack(ack),
    .all_released  (all_rel)
  );

  clock_reset_sequencer #(
    .N_CHANNELS    (1),
    .HOLD_CYCLES   (1),
    .STAGGER_CYCLES(1)
  ) dut_b (
    .clock         (clock),
    .reset         (reset_b),
    .chan_reset_req(req_b),
    .auto_out_clock(aoc_b),
    .auto_out_reset(rst_b),
    .chan_reset_ack(ack_b),
    .all_released  (all_rel_b)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  int           e;          // index of the edge most recently passed, from E0
  logic [N-1:0] ack_seen;   // sticky OR of ack across ticks

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after edge Ek.
  task automatic goto(input int k);
    while (e < k) begin
      @(posedge clock);
      #1;
      e++;
      ack_seen |= ack;
    end
  endtask

  // Hold reset for a few edges; the next edge after return is E0.
  task automatic do_reset_a();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset    = 1'b0;
    e        = -1;
    ack_seen = '0;
  endtask

  // Safety net: the sequence is fixed-length, this only fires on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    req      = '0;
    reset_b  = 1'b1;
    req_b    = '0;
    e        = -100;
    ack_seen = '0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end

    // Reset values.
    check("rst_in_reset", 32'(rst), 32'h1f);
    check("ack_in_reset", 32'(ack), 32'h0);
    check("all_in_reset", 32'(all_rel), 32'h0);
    check("b_rst_in_reset", 32'(rst_b), 32'h1);
    check("clk_fanout_high", 32'(aoc), 32'h1f);
    @(negedge clock);
    #1;
    check("clk_fanout_low", 32'(aoc), 32'h0);

    // Initial staggered release, with ch1 requesting from E2 onwards.
    @(posedge clock);
    #1;
    reset    = 1'b0;
    e        = -1;
    ack_seen = '0;
    goto(1);
    req[1] = 1'b1;
    goto(7);
    check("hold_e7", 32'(rst), 32'h1f);
    goto(8);
    check("rel_ch0_e8", 32'(rst), 32'h1e);
    goto(11);
    check("stagger_e11", 32'(rst), 32'h1e);
    goto(12);
    check("rel_ch1_e12", 32'(rst), 32'h1c);
    goto(16);
    check("rel_ch2_e16", 32'(rst), 32'h18);
    goto(20);
    check("rel_ch3_e20", 32'(rst), 32'h10);
    goto(23);
    check("all_low_e23", 32'(all_rel), 32'h0);
    goto(24);
    check("rel_ch4_e24", 32'(rst), 32'h00);
    check("all_high_e24", 32'(all_rel), 32'h1);
    check("no_ack_before_run", 32'(ack_seen), 32'h0);

    // Request held through HOLD/RELEASE is serviced from the first RUN cycle.
    goto(25);
    check("ch1_rereset_e25", 32'(rst), 32'h02);
    goto(29);
    req[2] = 1'b1;              // sampled at E30
    goto(30);
    check("ch1_ch2_e30", 32'(rst), 32'h06);
    goto(32);
    check("ch1_hold_e32", 32'(rst), 32'h06);
    check("ch1_noack_e32", 32'(ack), 32'h0);
    goto(33);
    check("ch1_done_e33", 32'(rst), 32'h04);
    check("ch1_ack_e33", 32'(ack), 32'h02);
    req[1] = 1'b0;
    goto(34);
    check("ch1_ack_once", 32'(ack), 32'h0);
    goto(37);
    check("ch2_hold_e37", 32'(rst), 32'h04);
    goto(38);
    check("ch2_done_e38", 32'(rst), 32'h00);
    check("ch2_ack_e38", 32'(ack), 32'h04);
    check("all_in_run", 32'(all_rel), 32'h1);
    req[2] = 1'b0;
    goto(39);
    check("ch2_ack_once", 32'(ack), 32'h0);

    // Simultaneous ch0 + ch3; held request must not re-trigger.
    goto(40);
    req = 5'b01001;             // sampled at E41
    goto(41);
    check("ch03_start_e41", 32'(rst), 32'h09);
    goto(48);
    check("ch03_hold_e48", 32'(rst), 32'h09);
    goto(49);
    check("ch03_done_e49", 32'(rst), 32'h00);
    check("ch03_ack_e49", 32'(ack), 32'h09);
    goto(52);
    check("held_no_retrig_rst", 32'(rst), 32'h00);
    check("held_no_retrig_ack", 32'(ack), 32'h00);
    req = '0;                   // sampled low at E53, re-arms
    goto(53);
    req[0] = 1'b1;              // sampled at E54
    goto(54);
    check("ch0_rearmed_e54", 32'(rst), 32'h01);
    goto(61);
    check("ch0_hold_e61", 32'(rst), 32'h01);
    goto(62);
    check("ch0_ack_e62", 32'(ack), 32'h01);
    check("ch0_done_e62", 32'(rst), 32'h00);
    req[0] = 1'b0;

    // ch4 re-reset, then global reset on the edge its ack would appear.
    goto(64);
    req[4] = 1'b1;              // sampled at E65
    goto(65);
    check("ch4_start_e65", 32'(rst), 32'h10);
    goto(72);
    reset  = 1'b1;              // sampled at E73, where ack would fire
    req[4] = 1'b0;
    goto(73);
    check("mid_rr_reset_rst", 32'(rst), 32'h1f);
    check("mid_rr_reset_ack", 32'(ack), 32'h0);
    check("mid_rr_reset_all", 32'(all_rel), 32'h0);

    // Clean restart, then reset at E15 in the middle of RELEASE.
    do_reset_a();
    goto(8);
    check("restart1_e8", 32'(rst), 32'h1e);
    goto(12);
    check("restart1_e12", 32'(rst), 32'h1c);
    goto(14);
    reset = 1'b1;               // sampled at E15
    goto(15);
    check("mid_rel_reset_rst", 32'(rst), 32'h1f);
    check("mid_rel_reset_all", 32'(all_rel), 32'h0);
    do_reset_a();
    goto(7);
    check("restart2_e7", 32'(rst), 32'h1f);
    goto(8);
    check("restart2_e8", 32'(rst), 32'h1e);
    goto(24);
    check("restart2_e24", 32'(rst), 32'h00);
    check("restart2_all", 32'(all_rel), 32'h1);
    check("restart2_no_ack", 32'(ack_seen), 32'h0);

    // Minimal instance: N=1, HOLD=1, STAGGER=1.
    reset_b = 1'b0;
    e       = -1;
    goto(0);
    check("b_hold_e0", 32'(rst_b), 32'h1);
    check("b_all_e0", 32'(all_rel_b), 32'h0);
    goto(1);
    check("b_rel_e1", 32'(rst_b), 32'h0);
    check("b_all_e1", 32'(all_rel_b), 32'h1);
    req_b = 1'b1;               // sampled at E2
    goto(2);
    check("b_rr_start_e2", 32'(rst_b), 32'h1);
    check("b_rr_noack_e2", 32'(ack_b), 32'h0);
    goto(3);
    check("b_rr_done_e3", 32'(rst_b), 32'h0);
    check("b_rr_ack_e3", 32'(ack_b), 32'h1);
    goto(4);
    check("b_ack_once_e4", 32'(ack_b), 32'h0);
    check("b_no_retrig_e4", 32'(rst_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
